fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single IF/ID register with a PC generator plus a DEPTH-entry prefetch queue. It sits between instruction memory and the decode stage. It issues at most one fetch per cycle to a synchronous memory with a fixed 1-cycle read latency and hands {instr, pc_plus} to decode with a valid/ready handshake. It supports redirect/flush on taken branches and stops fetching on HLT.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Provides the HLT opcode, an opcode extraction helper and the packed
// queue-entry layout used between fetch and decode at the default widths.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 16;
  localparam int unsigned CPU_INSTR_W = 16;
  localparam int unsigned OPCODE_W    = 4;

  localparam logic [3:0] OP_HLT = 4'hF;

  // One prefetch-queue entry: the instruction word and the address of the
  // instruction that follows it.
  typedef struct packed {
    logic [CPU_INSTR_W-1:0] instr;
    logic [CPU_ADDR_W-1:0]  pc_plus;
  } fetch_entry_t;

  // Opcode is the top OPCODE_W bits of an instruction of the given width.
  // The instruction is passed right-aligned (zero-extended) in 64 bits so a
  // single helper serves any instruction width up to 64.
  function automatic logic [3:0] opcode_of(input logic [63:0] instr,
                                           input int unsigned width);
    return 4'((instr >> (width - 32'd4)) & 64'hF);
  endfunction

  // True when the opcode halts instruction fetch.
  function automatic logic is_hlt_op(input logic [3:0] op);
    return (op == OP_HLT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x W synchronous FIFO used as the prefetch queue.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push / i_data   write i_data at the tail (ignored when full without pop)
//   i_pop             remove the head entry (ignored when empty)
//   i_flush           empty the FIFO and reset both pointers (wins over push/pop)
//   o_data            head entry (meaningless when o_empty=1)
//   o_count           number of valid entries, 0..DEPTH
//   o_full / o_empty  status flags derived from o_count
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // Qualify push/pop against the current fill level; a pop frees the slot
  // a simultaneous push needs.
  always_comb begin
    w_full  = (r_count == CNT_W'(DEPTH));
    w_empty = (r_count == CNT_W'(0));
    w_pop   = i_pop && !w_empty;
    w_push  = i_push && (!w_full || w_pop);
  end

  // Entry storage; contents are only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_tail] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_head];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding fetch to a
// 1-cycle-latency instruction memory, and a DEPTH-entry prefetch queue that
// hands {instr, pc_plus} to decode with a valid/ready handshake.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req, imem_addr          fetch request and its address
//   imem_rdata                   data for the request of the previous cycle
//   redirect_valid, redirect_pc  taken branch: flush queue, refetch from pc
//   out_valid, out_ready         decode handshake on the queue head
//   out_instr, out_pc_plus       head instruction and its address + PC_STEP
//   hlt                          sticky: an HLT was fetched, fetching stopped
//   pc_out                       current fetch PC
//   occupancy                    valid entries in the queue
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc_plus,
  output logic                       hlt,
  output logic [ADDR_W-1:0]          pc_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              r_halted;

  logic              w_out_valid;
  logic              w_pop;
  logic              w_credit;
  logic              w_issue;
  logic              w_rsp_push;
  logic              w_rsp_hlt;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;
  logic [ADDR_W-1:0] w_req_addr;
  logic [ADDR_W-1:0] w_fetch_pc_nxt;
  logic [ADDR_W-1:0] w_rsp_pc_plus;
  logic [ENT_W-1:0]  w_rsp_entry;
  logic [ENT_W-1:0]  w_head;

  // Issue, response-acceptance and next-PC decisions for this cycle.
  always_comb begin
    w_out_valid = !w_fifo_empty;
    // Decode flushes on a redirect, so its handshake that cycle is void.
    w_pop       = w_out_valid && out_ready && !redirect_valid;
    // Slots already spoken for: queued entries plus the response in flight.
    w_used      = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    w_credit    = !w_fifo_full && (w_used < (CNT_W+1)'(DEPTH));
    // A redirect always refetches, even out of the halted state.
    w_issue     = redirect_valid || (!r_halted && (w_credit || w_pop));

    // Responses arriving while halted (the fetch issued alongside the HLT)
    // or during a redirect belong to a dead path.
    w_rsp_push    = r_inflight && !r_halted && !redirect_valid;
    w_rsp_pc_plus = r_inflight_pc + ADDR_W'(PC_STEP);
    w_rsp_entry   = {imem_rdata, w_rsp_pc_plus};
    w_rsp_hlt     = w_rsp_push && is_hlt_op(opcode_of(64'(imem_rdata), INSTR_W));

    if (redirect_valid) begin
      w_req_addr = redirect_pc;
    end else begin
      w_req_addr = r_fetch_pc;
    end
    w_fetch_pc_nxt = w_req_addr + ADDR_W'(PC_STEP);
  end

  // PC generator and tracking of the single outstanding memory read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_fetch_pc    <= w_fetch_pc_nxt;
        r_inflight_pc <= w_req_addr;
      end
      r_inflight <= w_issue;
    end
  end

  // Sticky halt: set when an HLT enters the queue, cleared only by redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_rsp_hlt) begin
      r_halted <= 1'b1;
    end else begin
      r_halted <= r_halted;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_rsp_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign imem_req    = w_issue;
  assign imem_addr   = w_req_addr;
  assign out_valid   = w_out_valid;
  assign out_instr   = w_head[ENT_W-1 -: INSTR_W];
  assign out_pc_plus = w_head[ADDR_W-1:0];
  assign hlt         = r_halted;
  assign pc_out      = r_fetch_pc;
  assign occupancy   = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PC_STEP  = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc_plus;
  logic        hlt;
  logic [15:0] pc_out;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_plus    (out_pc_plus),
    .hlt            (hlt),
    .pc_out         (pc_out),
    .occupancy      (occupancy)
  );

  // Instruction memory contents: NOPs tagged with their address, one HLT.
  logic        hlt_en = 1'b0;
  logic [15:0] hlt_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && (a == hlt_addr)) return 16'hF000;
    return {4'h0, a[11:0]};
  endfunction

  // Synchronous memory, one-cycle read latency.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int n_checks = 0;
  int n_fail   = 0;
  fetch_entry_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery stream starting at a fetch address.
  task automatic expect_stream(input logic [15:0] start, input int n);
    logic [15:0] a;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      a = start + 16'(2 * i);
      sb.push_back('{instr: mem_word(a), pc_plus: a + 16'd2});
    end
  endtask

  // Score the handshake about to happen on the next edge, then advance.
  task automatic step();
    fetch_entry_t e;
    if (!rst && out_valid && out_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_delivery: got pc_plus %h expected no delivery", out_pc_plus);
      end else begin
        e = sb.pop_front();
        check("deliv_instr", 32'(out_instr), 32'(e.instr));
        check("deliv_pc_plus", 32'(out_pc_plus), 32'(e.pc_plus));
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        exp_req;
    logic [15:0] exp_pc;
    logic        exp_ov;
    logic [15:0] exp_pp;
    logic [2:0]  exp_occ;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic rq,
                              input logic [15:0] pc, input logic ov,
                              input logic [15:0] pp, input logic [2:0] oc);
    vec_t v;
    v.rst = r; v.rdy = rd; v.exp_req = rq; v.exp_pc = pc;
    v.exp_ov = ov; v.exp_pp = pp; v.exp_occ = oc;
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    // rst rdy req  pc_out    ov  pc_plus   occ
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 3'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 3'd1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 3'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006, 3'd1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 3'd0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002, 3'd1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0002, 3'd2);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0002, 3'd3);
    for (int i = 12; i < 17; i++)
      tbl[i] = mk(1'b0, 1'b0, 1'b0, 16'h0008, 1'b1, 16'h0002, 3'd4);
    tbl[17] = mk(1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0002, 3'd4);
    tbl[18] = mk(1'b0, 1'b1, 1'b1, 16'h000A, 1'b1, 16'h0004, 3'd3);
    tbl[19] = mk(1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0006, 3'd3);
    tbl[20] = mk(1'b0, 1'b1, 1'b1, 16'h000E, 1'b1, 16'h0008, 3'd3);
    tbl[21] = mk(1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h000A, 3'd3);

    repeat (2) @(posedge clk);
    #1;

    // Table: reset, streaming fill, mid-stream reset, stall to full, drain.
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst;
      out_ready = tbl[i].rdy;
      redirect_valid = 1'b0;
      if (tbl[i].rst) expect_stream(RESET_PC, 40);
      #1;
      check($sformatf("t%0d_pc_out", i), 32'(pc_out), 32'(tbl[i].exp_pc));
      check($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      check($sformatf("t%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].exp_occ));
      check($sformatf("t%0d_hlt", i), 32'(hlt), 32'd0);
      if (!tbl[i].rst) begin
        check($sformatf("t%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
        if (tbl[i].exp_req) check($sformatf("t%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].exp_pc));
      end
      if (tbl[i].exp_ov) check($sformatf("t%0d_out_pc_plus", i), 32'(out_pc_plus), 32'(tbl[i].exp_pp));
      step();
    end

    // Redirect with occupancy 3 and a read in flight.
    check("pre_redir_occ", 32'(occupancy), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    expect_stream(16'h0100, 40);
    #1;
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h0100);
    step();
    redirect_valid = 1'b0;
    #1;
    check("redir_occ0", 32'(occupancy), 32'd0);
    check("redir_ov0", 32'(out_valid), 32'd0);
    check("redir_pc_out", 32'(pc_out), 32'h0102);
    step();
    check("redir_first_ov", 32'(out_valid), 32'd1);
    check("redir_first_pp", 32'(out_pc_plus), 32'h0102);
    repeat (6) step();

    // HLT at 0x0006.
    hlt_en = 1'b1;
    hlt_addr = 16'h0006;
    out_ready = 1'b1;
    rst = 1'b1;
    expect_stream(16'h0000, 4);
    step();
    rst = 1'b0;
    repeat (5) step();
    check("hlt_set", 32'(hlt), 32'd1);
    check("hlt_ov", 32'(out_valid), 32'd1);
    check("hlt_instr", 32'(out_instr), 32'h0000F000);
    check("hlt_pp", 32'(out_pc_plus), 32'h0008);
    check("hlt_req0", 32'(imem_req), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("halted%0d_req", i), 32'(imem_req), 32'd0);
      check($sformatf("halted%0d_ov", i), 32'(out_valid), 32'd0);
      check($sformatf("halted%0d_occ", i), 32'(occupancy), 32'd0);
      check($sformatf("halted%0d_hlt", i), 32'(hlt), 32'd1);
      step();
    end
    check("hlt_all_delivered", 32'(sb.size()), 32'd0);

    // Redirect out of halt.
    expect_stream(16'h0000, 4);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    #1;
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", 32'(imem_addr), 32'h0000);
    step();
    redirect_valid = 1'b0;
    #1;
    check("resume_hlt_clr", 32'(hlt), 32'd0);
    check("resume_pc_out", 32'(pc_out), 32'h0002);
    step();
    check("resume_ov", 32'(out_valid), 32'd1);
    check("resume_pp", 32'(out_pc_plus), 32'h0002);
    repeat (4) step();
    check("resume_all_delivered", 32'(sb.size()), 32'd0);

    // Address wrap at 0xFFFE.
    hlt_en = 1'b0;
    expect_stream(16'hFFFE, 20);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    check("wrap_addr0", 32'(imem_addr), 32'hFFFE);
    step();
    redirect_valid = 1'b0;
    #1;
    check("wrap_pc_out", 32'(pc_out), 32'h0000);
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr1", 32'(imem_addr), 32'h0000);
    step();
    check("wrap_ov", 32'(out_valid), 32'd1);
    check("wrap_pp", 32'(out_pc_plus), 32'h0000);
    repeat (5) step();

    // Asynchronous reset with occupancy 2 and a read in flight.
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("mid_pre_occ", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #2;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_hlt", 32'(hlt), 32'd0);
    check("arst_pc_out", 32'(pc_out), 32'(RESET_PC));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    expect_stream(RESET_PC, 40);
    #1;
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", 32'(imem_addr), 32'(RESET_PC));
    step();
    step();
    check("post_rst_ov", 32'(out_valid), 32'd1);
    check("post_rst_pp", 32'(out_pc_plus), 32'h0002);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
